// File: rtl/lbp_row_scheduler_if.sv
// Row-job channel between the scheduler and the two LBP worker engines.
// Offer/accept per engine, shared row index, per-engine completion pulse.
interface lbp_row_scheduler_if #(
  parameter int unsigned ROW_W = 7
) ();
  logic [1:0]       job_valid;
  logic [1:0]       job_ready;
  logic [ROW_W-1:0] job_row;
  logic [1:0]       job_done;

  modport master (
    output job_valid,
    output job_row,
    input  job_ready,
    input  job_done
  );

  modport slave (
    input  job_valid,
    input  job_row,
    output job_ready,
    output job_done
  );
endinterface

// File: rtl/lbp_row_scheduler.sv
// Round-robin dispatcher of interior image rows to two LBP engines; tracks
// per-engine busy/completion and signals finish once every row is done.
module lbp_row_scheduler #(
  parameter int unsigned IMG_H = 128,
  parameter int unsigned ROW_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  lbp_row_scheduler_if.master  job,
  output logic                 busy,
  output logic                 finish,
  output logic [ROW_W-1:0]     rows_done,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  // Last interior row index; also the total job count per frame.
  localparam logic [ROW_W-1:0] N_JOBS = ROW_W'(IMG_H - 2);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] next_row_q, next_row_d;
  logic [ROW_W-1:0] rows_done_q, rows_done_d;
  logic [1:0]       eng_busy_q, eng_busy_d;
  logic             rr_q, rr_d;
  logic [1:0]       job_valid_q, job_valid_d;
  logic [ROW_W-1:0] job_row_q, job_row_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;

  logic [1:0] hs;
  logic       hs_eng;
  logic       rr_oth;
  logic [1:0] done_ok;
  logic [1:0] done_bad;
  logic [1:0] done_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      next_row_q  <= ROW_W'(1);
      rows_done_q <= '0;
      eng_busy_q  <= '0;
      rr_q        <= 1'b0;
      job_valid_q <= '0;
      job_row_q   <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_row_q  <= next_row_d;
      rows_done_q <= rows_done_d;
      eng_busy_q  <= eng_busy_d;
      rr_q        <= rr_d;
      job_valid_q <= job_valid_d;
      job_row_q   <= job_row_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    next_row_d  = next_row_q;
    rows_done_d = rows_done_q;
    eng_busy_d  = eng_busy_q;
    rr_d        = rr_q;
    job_valid_d = job_valid_q;
    job_row_d   = job_row_q;
    err_d       = err_q;

    hs       = job_valid_q & job.job_ready;
    hs_eng   = job_valid_q[1];
    rr_oth   = ~rr_q;
    done_ok  = job.job_done & eng_busy_q;
    done_bad = job.job_done & ~eng_busy_q;
    done_cnt = {1'b0, done_ok[0]} + {1'b0, done_ok[1]};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (|job.job_done) err_d = 1'b1;
        if (start) begin
          state_d     = S_DISPATCH;
          next_row_d  = ROW_W'(1);
          rows_done_d = '0;
          eng_busy_d  = '0;
          rr_d        = 1'b0;
          job_valid_d = '0;
        end
      end
      S_DISPATCH, S_DRAIN: begin
        if (|done_bad) err_d = 1'b1;
        // Completions clear first so a same-cycle handshake on the other
        // engine still lands on top of the updated busy vector.
        eng_busy_d  = eng_busy_q & ~done_ok;
        rows_done_d = rows_done_q + ROW_W'(done_cnt);
        if (state_q == S_DISPATCH) begin
          if (|hs) begin
            eng_busy_d[hs_eng] = 1'b1;
            next_row_d         = next_row_q + ROW_W'(1);
            rr_d               = ~hs_eng;
            job_valid_d        = '0;
            if (job_row_q == N_JOBS) state_d = S_DRAIN;
          end else if (job_valid_q == 2'b00) begin
            if (!eng_busy_q[rr_q]) begin
              job_valid_d[rr_q] = 1'b1;
              job_row_d         = next_row_q;
            end else if (!eng_busy_q[rr_oth]) begin
              job_valid_d[rr_oth] = 1'b1;
              job_row_d           = next_row_q;
            end
          end
        end else if (eng_busy_q == 2'b00 && rows_done_q == N_JOBS) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
    finish_d = (state_d == S_DONE);
  end

  assign job.job_valid = job_valid_q;
  assign job.job_row   = job_row_q;
  assign busy          = busy_q;
  assign finish        = finish_q;
  assign rows_done     = rows_done_q;
  assign err           = err_q;

endmodule
